// File: rtl/snake_head_driver.sv
// Movement engine for the 8x8 snake game: turns buttons into a legal direction and
// advances the head one cell per game tick until the collision checker reports a hit.
module snake_head_driver #(
    parameter int          TICK_DIV   = 25_000_000,
    parameter logic [5:0]  START_HEAD = 6'd27,
    parameter logic [1:0]  START_DIR  = 2'b00
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic       btn_right_i,
    input  logic       btn_down_i,
    input  logic       btn_left_i,
    input  logic       btn_up_i,
    input  logic       colide_i,
    output logic [5:0] head_o,
    output logic [1:0] direction_o,
    output logic       step_o,
    output logic       running_o,
    output logic       dead_o
);

    localparam int              CW        = $clog2(TICK_DIV);
    localparam logic [CW-1:0]   TICK_LAST = CW'(TICK_DIV - 1);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DEAD = 2'b10;

    localparam logic [1:0] DIR_RIGHT = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_UP    = 2'b11;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [5:0]    head_q, head_d;
    logic [1:0]    dir_q, dir_d;
    logic [1:0]    last_dir_q, last_dir_d;
    logic          step_q, step_d;

    logic          btn_any;
    logic [1:0]    req;
    logic [2:0]    row_n, col_n;

    // Fixed button priority: RIGHT > DOWN > LEFT > UP.
    always_comb begin
        btn_any = btn_right_i | btn_down_i | btn_left_i | btn_up_i;
        if (btn_right_i)     req = DIR_RIGHT;
        else if (btn_down_i) req = DIR_DOWN;
        else if (btn_left_i) req = DIR_LEFT;
        else                 req = DIR_UP;
    end

    always_comb begin
        row_n = head_q[5:3];
        col_n = head_q[2:0];
        case (dir_q)
            DIR_RIGHT: col_n = head_q[2:0] + 3'd1;
            DIR_DOWN:  row_n = head_q[5:3] + 3'd1;
            DIR_LEFT:  col_n = head_q[2:0] - 3'd1;
            default:   row_n = head_q[5:3] - 3'd1;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        head_d     = head_q;
        dir_d      = dir_q;
        last_dir_d = last_dir_q;
        step_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (cnt_q == TICK_LAST) begin
                    cnt_d = '0;
                    if (colide_i) begin
                        state_d = ST_DEAD;
                    end else begin
                        head_d     = {row_n, col_n};
                        last_dir_d = dir_q;
                        step_d     = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
                // Compare against the last executed move so two quick turns cannot reverse.
                if (btn_any && (req != (last_dir_q ^ 2'b10))) begin
                    dir_d = req;
                end
            end
            ST_DEAD: begin
                if (start_i) begin
                    state_d    = ST_RUN;
                    head_d     = START_HEAD;
                    dir_d      = START_DIR;
                    last_dir_d = START_DIR;
                    cnt_d      = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            head_q     <= START_HEAD;
            dir_q      <= START_DIR;
            last_dir_q <= START_DIR;
            step_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            head_q     <= head_d;
            dir_q      <= dir_d;
            last_dir_q <= last_dir_d;
            step_q     <= step_d;
        end
    end

    assign head_o      = head_q;
    assign direction_o = dir_q;
    assign step_o      = step_q;
    assign running_o   = (state_q == ST_RUN);
    assign dead_o      = (state_q == ST_DEAD);

endmodule
